// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//
// Writer side of the processor's instruction/data RAM. Takes a byte stream
// (valid/ready), assembles big-endian words and writes them to consecutive
// RAM addresses starting at 0. Holds the processor in reset until a complete
// program has been stored.
//
// Frame: count word N, then N program words, then (optionally) a checksum
// word. Every word is sent high byte first.
//
// Optional feature: define LOADER_CHECKSUM_EN to add the checksum word
// (XOR of N and all program words). A mismatching checksum ends in ERR.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   start      one-cycle request to begin a load (honoured in IDLE/DONE/ERR)
//   in_data    stream byte
//   in_valid   in_data valid
//   in_ready   loader accepts a byte this cycle
//   ram_we     RAM write enable, one-cycle pulse
//   ram_addr   RAM write address
//   ram_wdata  RAM write data
//   cpu_hold   processor held in reset while 1
//   load_done  program stored, processor released
//   load_err   load aborted
// -----------------------------------------------------------------------------
module program_loader #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [DATA_W-1:0] DEPTH_W = DATA_W'(DEPTH);

  typedef enum logic [3:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    DAT_HI,
    DAT_LO,
`ifdef LOADER_CHECKSUM_EN
    CHK_HI,
    CHK_LO,
`endif
    FLUSH,
    DONE,
    ERR
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-9:0]   hi_q, hi_d;
  logic [CNT_W-1:0]    n_q, n_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic                in_ready_q, in_ready_d;
  logic                cpu_hold_q, cpu_hold_d;
  logic                load_done_q, load_done_d;
  logic                load_err_q, load_err_d;
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0]   acc_q, acc_d;
`endif

  logic              accept;
  logic [DATA_W-1:0] word;
  logic              begin_load;

  // in_ready_q mirrors the current state, so this is the real handshake.
  assign accept = in_valid && in_ready_q;
  assign word   = {hi_q, in_data};

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours regardless of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      hi_q        <= '0;
      n_q         <= '0;
      idx_q       <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      in_ready_q  <= 1'b0;
      cpu_hold_q  <= 1'b1;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      acc_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      n_q         <= n_d;
      idx_q       <= idx_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      in_ready_q  <= in_ready_d;
      cpu_hold_q  <= cpu_hold_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
`ifdef LOADER_CHECKSUM_EN
      acc_q       <= acc_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    hi_d        = hi_q;
    n_d         = n_q;
    idx_d       = idx_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
`ifdef LOADER_CHECKSUM_EN
    acc_d       = acc_q;
`endif
    begin_load  = 1'b0;

    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          begin_load = 1'b1;
          state_d    = HDR_HI;
        end
      end
      HDR_HI: if (accept) begin
        hi_d    = in_data;
        state_d = HDR_LO;
      end
      HDR_LO: if (accept) begin
        if (word == '0 || word > DEPTH_W) begin
          state_d = ERR;
        end else begin
          n_d     = word[CNT_W-1:0];
          state_d = DAT_HI;
`ifdef LOADER_CHECKSUM_EN
          acc_d   = word;
`endif
        end
      end
      DAT_HI: if (accept) begin
        hi_d    = in_data;
        state_d = DAT_LO;
      end
      DAT_LO: if (accept) begin
        ram_we_d    = 1'b1;
        ram_addr_d  = idx_q;
        ram_wdata_d = word;
`ifdef LOADER_CHECKSUM_EN
        acc_d       = acc_q ^ word;
`endif
        if ({1'b0, idx_q} == n_q - CNT_W'(1)) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = CHK_HI;
`else
          state_d = FLUSH;
`endif
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = DAT_HI;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHK_HI: if (accept) begin
        hi_d    = in_data;
        state_d = CHK_LO;
      end
      CHK_LO: if (accept) begin
        state_d = (word == acc_q) ? FLUSH : ERR;
      end
`endif
      FLUSH:   state_d = DONE;
      default: state_d = IDLE;
    endcase

    // Restart clears the word counter, address and checksum accumulator.
    if (begin_load) begin
      idx_d      = '0;
      ram_addr_d = '0;
`ifdef LOADER_CHECKSUM_EN
      acc_d      = '0;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Registered status outputs, derived from the upcoming state
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready_d = 1'b0;
    case (state_d)
`ifdef LOADER_CHECKSUM_EN
      CHK_HI, CHK_LO,
`endif
      HDR_HI, HDR_LO, DAT_HI, DAT_LO: in_ready_d = 1'b1;
      default:                        in_ready_d = 1'b0;
    endcase
    // Release only from the second DONE cycle: the final write is then two
    // cycles behind us, and leaving DONE re-asserts hold on the same edge.
    load_done_d = (state_q == DONE) && (state_d == DONE);
    cpu_hold_d  = !load_done_d;
    load_err_d  = (state_d == ERR);
  end

  assign in_ready  = in_ready_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign load_done = load_done_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
//
// Directed testbench for program_loader. A monitor records every RAM write
// (address, data, cycle) and the cycle load_done rises; scenario tasks drive
// frames and compare against hand-computed values. Build with
// LOADER_CHECKSUM_EN defined to exercise the checksum word as well.
// -----------------------------------------------------------------------------
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        ram_we;
  logic [5:0]  ram_addr;
  logic [15:0] ram_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  program_loader #(.ADDR_W(6), .DATA_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [15:0] prog [0:63];
  bit          chk_corrupt = 1'b0;

  // Write monitor, sampled 1 time unit after each rising edge.
  int          cyc = 0;
  int          wr_cnt = 0;
  logic [5:0]  wr_addr [0:255];
  logic [15:0] wr_data [0:255];
  int          wr_cyc  [0:255];
  int          done_cyc = -1;
  logic        done_prev = 1'b0;

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (ram_we && wr_cnt < 256) begin
      wr_addr[wr_cnt] = ram_addr;
      wr_data[wr_cnt] = ram_wdata;
      wr_cyc[wr_cnt]  = cyc;
      wr_cnt = wr_cnt + 1;
    end
    if (load_done && !done_prev) done_cyc = cyc;
    done_prev = load_done;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all called and returning on a falling edge)
  // ---------------------------------------------------------------------------
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_stall);
    int guard;
    if (max_stall > 0) repeat ($urandom_range(0, max_stall)) @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    guard    = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_byte_timeout: in_ready=%0b required 1 within 100 cycles", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input int max_stall);
    send_byte(w[15:8], max_stall);
    send_byte(w[7:0], max_stall);
  endtask

  // Sends header, prog[0..n-1] and, when enabled, the checksum word.
  task automatic load_program(input int n, input int max_stall);
    logic [15:0] acc;
    acc = 16'(n);
    send_word(16'(n), max_stall);
    for (int i = 0; i < n; i++) begin
      send_word(prog[i], max_stall);
      acc = acc ^ prog[i];
    end
`ifdef LOADER_CHECKSUM_EN
    send_word(chk_corrupt ? (acc ^ 16'h0001) : acc, max_stall);
`endif
  endtask

  task automatic wait_end(input int max);
    int g;
    g = 0;
    while (!(load_done || load_err) && g < max) begin
      @(negedge clk);
      g++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  localparam logic [26:0] RESET_VEC = {1'b0, 1'b0, 6'd0, 16'h0000, 1'b1, 1'b0, 1'b0};

  task automatic test_reset();
    int base;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, ram_we, ram_addr, ram_wdata, cpu_hold, load_done, load_err} !== RESET_VEC) begin
      failures++;
      $display("FAIL reset_values: got %h required %h",
               {in_ready, ram_we, ram_addr, ram_wdata, cpu_hold, load_done, load_err}, RESET_VEC);
    end
    rst = 1'b1;
    @(negedge clk);

    // Abort a N=5 load after three words.
    for (int i = 0; i < 5; i++) prog[i] = 16'h0100 + 16'(i);
    pulse_start();
    send_word(16'd5, 0);
    for (int i = 0; i < 3; i++) send_word(prog[i], 0);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({in_ready, ram_we, ram_addr, ram_wdata, cpu_hold, load_done, load_err} !== RESET_VEC) begin
      failures++;
      $display("FAIL reset_mid_load: got %h required %h",
               {in_ready, ram_we, ram_addr, ram_wdata, cpu_hold, load_done, load_err}, RESET_VEC);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Reload after release.
    base = wr_cnt;
    pulse_start();
    load_program(5, 0);
    wait_end(20);
    checks++;
    if (load_done !== 1'b1 || cpu_hold !== 1'b0) begin
      failures++;
      $display("FAIL reset_reload_done: load_done=%0b cpu_hold=%0b required 1/0", load_done, cpu_hold);
    end
    checks++;
    if (wr_cnt - base !== 5) begin
      failures++;
      $display("FAIL reset_reload_count: got %0d writes required 5", wr_cnt - base);
    end else begin
      checks++;
      if (wr_addr[base+4] !== 6'd4 || wr_data[base+4] !== 16'h0104) begin
        failures++;
        $display("FAIL reset_reload_last: addr=%0d data=%h required 4/0104",
                 wr_addr[base+4], wr_data[base+4]);
      end
    end
  endtask

  task automatic test_basic_load();
    int base;
    logic [15:0] exp_d [0:2];
    exp_d[0] = 16'h0005;
    exp_d[1] = 16'h0112;
    exp_d[2] = 16'h0234;
    for (int i = 0; i < 3; i++) prog[i] = exp_d[i];
    base = wr_cnt;
    pulse_start();
    load_program(3, 0);
    wait_end(20);
    checks++;
    if (wr_cnt - base !== 3) begin
      failures++;
      $display("FAIL basic_count: got %0d writes required 3", wr_cnt - base);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wr_addr[base+i] !== 6'(i) || wr_data[base+i] !== exp_d[i]) begin
          failures++;
          $display("FAIL basic_write%0d: addr=%0d data=%h required %0d/%h",
                   i, wr_addr[base+i], wr_data[base+i], i, exp_d[i]);
        end
      end
      checks++;
      if (wr_cyc[base+1] - wr_cyc[base] !== 2 || wr_cyc[base+2] - wr_cyc[base+1] !== 2) begin
        failures++;
        $display("FAIL basic_write_spacing: gaps %0d,%0d required 2,2",
                 wr_cyc[base+1] - wr_cyc[base], wr_cyc[base+2] - wr_cyc[base+1]);
      end
`ifndef LOADER_CHECKSUM_EN
      checks++;
      if (done_cyc - wr_cyc[base+2] !== 2) begin
        failures++;
        $display("FAIL basic_done_latency: got %0d cycles required 2", done_cyc - wr_cyc[base+2]);
      end
`endif
    end
    checks++;
    if ({load_done, cpu_hold, load_err, in_ready} !== 4'b1000) begin
      failures++;
      $display("FAIL basic_status: done/hold/err/ready=%b required 1000",
               {load_done, cpu_hold, load_err, in_ready});
    end
  endtask

  task automatic test_illegal_count();
    int base;
    base = wr_cnt;
    pulse_start();
    send_word(16'h0000, 0);
    checks++;
    if ({load_err, cpu_hold, load_done, in_ready} !== 4'b1100) begin
      failures++;
      $display("FAIL illegal_zero: err/hold/done/ready=%b required 1100",
               {load_err, cpu_hold, load_done, in_ready});
    end
    pulse_start();
    checks++;
    if (load_err !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL illegal_clear: load_err=%0b in_ready=%0b required 0/1", load_err, in_ready);
    end
    send_word(16'h0041, 0);
    checks++;
    if (load_err !== 1'b1 || cpu_hold !== 1'b1) begin
      failures++;
      $display("FAIL illegal_65: load_err=%0b cpu_hold=%0b required 1/1", load_err, cpu_hold);
    end
    checks++;
    if (wr_cnt !== base) begin
      failures++;
      $display("FAIL illegal_no_write: got %0d writes required 0", wr_cnt - base);
    end
    prog[0] = 16'hCAFE;
    prog[1] = 16'h0F0F;
    pulse_start();
    load_program(2, 0);
    wait_end(20);
    checks++;
    if (load_done !== 1'b1 || load_err !== 1'b0 || wr_cnt - base !== 2) begin
      failures++;
      $display("FAIL illegal_reload: done=%0b err=%0b writes=%0d required 1/0/2",
               load_done, load_err, wr_cnt - base);
    end
  endtask

  task automatic test_full_depth();
    int base;
    int bad;
    for (int i = 0; i < 64; i++) prog[i] = 16'hA000 + 16'(i);
    base = wr_cnt;
    pulse_start();
    load_program(64, 2);
    wait_end(40);
    repeat (4) @(negedge clk);
    checks++;
    if (wr_cnt - base !== 64) begin
      failures++;
      $display("FAIL full_count: got %0d writes required 64", wr_cnt - base);
    end else begin
      bad = 0;
      for (int i = 0; i < 64; i++) begin
        checks++;
        if (wr_addr[base+i] !== 6'(i) || wr_data[base+i] !== 16'hA000 + 16'(i)) begin
          failures++;
          bad++;
          if (bad < 5)
            $display("FAIL full_write%0d: addr=%0d data=%h required %0d/%h",
                     i, wr_addr[base+i], wr_data[base+i], i, 16'hA000 + 16'(i));
        end
      end
    end
    checks++;
    if (load_done !== 1'b1 || cpu_hold !== 1'b0) begin
      failures++;
      $display("FAIL full_done: load_done=%0b cpu_hold=%0b required 1/0", load_done, cpu_hold);
    end
  endtask

  task automatic test_restart_from_done();
    int base;
    base = wr_cnt;
    // Offered bytes while not ready must not be consumed.
    in_data  = 8'h55;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (wr_cnt !== base || load_done !== 1'b1) begin
      failures++;
      $display("FAIL restart_idle_bytes: writes=%0d load_done=%0b required 0/1",
               wr_cnt - base, load_done);
    end
    pulse_start();
    checks++;
    if (cpu_hold !== 1'b1 || load_done !== 1'b0) begin
      failures++;
      $display("FAIL restart_hold: cpu_hold=%0b load_done=%0b required 1/0", cpu_hold, load_done);
    end
    prog[0] = 16'hBEEF;
    prog[1] = 16'h1234;
    load_program(2, 0);
    wait_end(20);
    checks++;
    if (wr_cnt - base !== 2 || wr_addr[base] !== 6'd0 || wr_data[base] !== 16'hBEEF ||
        wr_addr[base+1] !== 6'd1 || wr_data[base+1] !== 16'h1234) begin
      failures++;
      $display("FAIL restart_overwrite: writes=%0d a0=%0d d0=%h a1=%0d d1=%h required 2/0/BEEF/1/1234",
               wr_cnt - base, wr_addr[base], wr_data[base], wr_addr[base+1], wr_data[base+1]);
    end
    checks++;
    if (load_done !== 1'b1) begin
      failures++;
      $display("FAIL restart_done: load_done=%0b required 1", load_done);
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    int base;
    prog[0] = 16'h1111;
    prog[1] = 16'h2222;
    base = wr_cnt;
    chk_corrupt = 1'b0;
    pulse_start();
    load_program(2, 0);  // checksum sent: 0x0002 ^ 0x1111 ^ 0x2222 = 0x3331
    wait_end(20);
    checks++;
    if (load_done !== 1'b1 || load_err !== 1'b0) begin
      failures++;
      $display("FAIL chk_good: done=%0b err=%0b required 1/0", load_done, load_err);
    end
    base = wr_cnt;
    chk_corrupt = 1'b1;
    pulse_start();
    load_program(2, 0);  // checksum sent: 0x3330
    chk_corrupt = 1'b0;
    wait_end(20);
    checks++;
    if (load_err !== 1'b1 || cpu_hold !== 1'b1 || load_done !== 1'b0) begin
      failures++;
      $display("FAIL chk_bad: err=%0b hold=%0b done=%0b required 1/1/0", load_err, cpu_hold, load_done);
    end
    checks++;
    if (wr_cnt - base !== 2 || wr_data[base] !== 16'h1111 || wr_data[base+1] !== 16'h2222) begin
      failures++;
      $display("FAIL chk_bad_writes: writes=%0d d0=%h d1=%h required 2/1111/2222",
               wr_cnt - base, wr_data[base], wr_data[base+1]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_load();
    test_illegal_count();
    test_full_depth();
    test_restart_from_done();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
